// File: rtl/ahb_lite_master.sv
// AHB-lite single-initiator bus master.
// Turns a valid/ready command stream into AHB-lite SINGLE transfers and returns
// one in-order response per command. A registered address stage drives the
// address-phase signals. A registered data stage drives HWDATA and watches
// HREADY/HRESP. The address phase of one command overlaps the data phase of
// the previous one, which gives one transfer per cycle when there are no wait
// states.
// Only DATA_W = 32 is supported, and ADDR_W must be at least 2.
module ahb_lite_master #(
    parameter int         ADDR_W    = 32,
    parameter int         DATA_W    = 32,
    parameter logic [3:0] HPROT_VAL = 4'b0011
) (
    input  logic              HCLK,
    input  logic              HRESET,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic              cmd_write,
    input  logic [ADDR_W-1:0] cmd_addr,
    input  logic [1:0]        cmd_size,
    input  logic [DATA_W-1:0] cmd_wdata,
    output logic              rsp_valid,
    output logic [DATA_W-1:0] rsp_rdata,
    output logic              rsp_error,
    output logic              busy,
    output logic [ADDR_W-1:0] HADDR,
    output logic [1:0]        HTRANS,
    output logic              HWRITE,
    output logic [2:0]        HSIZE,
    output logic [2:0]        HBURST,
    output logic [3:0]        HPROT,
    output logic [DATA_W-1:0] HWDATA,
    input  logic              HREADY,
    input  logic [DATA_W-1:0] HRDATA,
    input  logic              HRESP
);

    // Only the two transfer types a SINGLE-only master ever issues.
    typedef enum logic [1:0] {
        TRANS_IDLE   = 2'b00,
        TRANS_NONSEQ = 2'b10
    } htrans_e;

    // Address stage: the transfer currently presented on the address bus.
    logic              a_vld_q,   a_vld_d;
    htrans_e           htrans_q,  htrans_d;
    logic [ADDR_W-1:0] haddr_q,   haddr_d;
    logic              hwrite_q,  hwrite_d;
    logic [1:0]        hsize_q,   hsize_d;
    logic [DATA_W-1:0] a_wdata_q, a_wdata_d;

    // Data stage: the transfer whose data phase is in progress.
    logic              d_vld_q,   d_vld_d;
    logic              d_write_q, d_write_d;
    logic [DATA_W-1:0] d_wdata_q, d_wdata_d;

    // Response registers: a single-cycle pulse after each data phase completes.
    logic              rsp_valid_q, rsp_valid_d;
    logic [DATA_W-1:0] rsp_rdata_q, rsp_rdata_d;
    logic              rsp_error_q, rsp_error_d;

    logic              cmd_accept;
    logic              addr_done;
    logic              data_done;
    logic [1:0]        eff_size;
    logic [ADDR_W-1:0] aligned_addr;

    // Handshake and size/alignment decode of the incoming command.
    // ready depends only on our own state and HREADY, never on cmd_valid.
    always_comb begin
        cmd_ready    = !HRESET && (!a_vld_q || HREADY);
        cmd_accept   = cmd_valid && cmd_ready;
        addr_done    = a_vld_q && HREADY;
        data_done    = d_vld_q && HREADY;
        eff_size     = (cmd_size == 2'd3) ? 2'd2 : cmd_size;
        aligned_addr = cmd_addr;
        if (eff_size == 2'd1) begin
            aligned_addr[0] = 1'b0;
        end else if (eff_size == 2'd2) begin
            aligned_addr[1:0] = 2'b00;
        end
    end

    // Address stage next state.
    // A new command replaces a finished address phase on the same edge.
    // With nothing new, a finished phase drops to IDLE and address/control hold.
    always_comb begin
        a_vld_d   = a_vld_q;
        htrans_d  = htrans_q;
        haddr_d   = haddr_q;
        hwrite_d  = hwrite_q;
        hsize_d   = hsize_q;
        a_wdata_d = a_wdata_q;
        if (cmd_accept) begin
            a_vld_d   = 1'b1;
            htrans_d  = TRANS_NONSEQ;
            haddr_d   = aligned_addr;
            hwrite_d  = cmd_write;
            hsize_d   = eff_size;
            a_wdata_d = cmd_wdata;
        end else if (addr_done) begin
            a_vld_d  = 1'b0;
            htrans_d = TRANS_IDLE;
        end
    end

    // Data stage next state.
    // A finished address phase moves into the data stage. Otherwise a finished
    // data phase simply empties it. Write data stays put through wait states.
    always_comb begin
        d_vld_d   = d_vld_q;
        d_write_d = d_write_q;
        d_wdata_d = d_wdata_q;
        if (addr_done) begin
            d_vld_d   = 1'b1;
            d_write_d = hwrite_q;
            d_wdata_d = a_wdata_q;
        end else if (data_done) begin
            d_vld_d = 1'b0;
        end
    end

    // Response capture: one pulse, registered from the completing data phase.
    always_comb begin
        rsp_valid_d = 1'b0;
        rsp_rdata_d = '0;
        rsp_error_d = 1'b0;
        if (data_done) begin
            rsp_valid_d = 1'b1;
            rsp_rdata_d = d_write_q ? '0 : HRDATA;
            rsp_error_d = HRESP;
        end
    end

    // All state registers. Synchronous reset wins and abandons in-flight work.
    always_ff @(posedge HCLK) begin
        if (HRESET) begin
            a_vld_q     <= 1'b0;
            htrans_q    <= TRANS_IDLE;
            haddr_q     <= '0;
            hwrite_q    <= 1'b0;
            hsize_q     <= 2'd0;
            a_wdata_q   <= '0;
            d_vld_q     <= 1'b0;
            d_write_q   <= 1'b0;
            d_wdata_q   <= '0;
            rsp_valid_q <= 1'b0;
            rsp_rdata_q <= '0;
            rsp_error_q <= 1'b0;
        end else begin
            a_vld_q     <= a_vld_d;
            htrans_q    <= htrans_d;
            haddr_q     <= haddr_d;
            hwrite_q    <= hwrite_d;
            hsize_q     <= hsize_d;
            a_wdata_q   <= a_wdata_d;
            d_vld_q     <= d_vld_d;
            d_write_q   <= d_write_d;
            d_wdata_q   <= d_wdata_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_rdata_q <= rsp_rdata_d;
            rsp_error_q <= rsp_error_d;
        end
    end

    // Bus and response outputs driven straight from the stage registers.
    always_comb begin
        HADDR     = haddr_q;
        HTRANS    = htrans_q;
        HWRITE    = hwrite_q;
        HSIZE     = {1'b0, hsize_q};
        HBURST    = 3'b000;
        HPROT     = HPROT_VAL;
        HWDATA    = (d_vld_q && d_write_q) ? d_wdata_q : '0;
        busy      = a_vld_q || d_vld_q;
        rsp_valid = rsp_valid_q;
        rsp_rdata = rsp_rdata_q;
        rsp_error = rsp_error_q;
    end

endmodule

// File: tb/tb_ahb_lite_master.sv
// Self-checking bench for ahb_lite_master.
// Directed command/slave vectors with hand-computed expectations, plus a
// queue-based transaction model checked against the bus every cycle.
module tb_ahb_lite_master;

    logic        hclk = 1'b0;
    logic        hreset;
    logic        cmdValid;
    logic        cmdReady;
    logic        cmdWrite;
    logic [31:0] cmdAddr;
    logic [1:0]  cmdSize;
    logic [31:0] cmdWdata;
    logic        rspValid;
    logic [31:0] rspRdata;
    logic        rspError;
    logic        busy;
    logic [31:0] haddr;
    logic [1:0]  htrans;
    logic        hwrite;
    logic [2:0]  hsize;
    logic [2:0]  hburst;
    logic [3:0]  hprot;
    logic [31:0] hwdata;
    logic        hready;
    logic [31:0] hrdata;
    logic        hresp;

    int errors = 0;
    int checks = 0;
    bit modelOn = 1'b0;
    int pulses;

    ahb_lite_master #(
        .ADDR_W(32),
        .DATA_W(32),
        .HPROT_VAL(4'b0011)
    ) dut (
        .HCLK(hclk),
        .HRESET(hreset),
        .cmd_valid(cmdValid),
        .cmd_ready(cmdReady),
        .cmd_write(cmdWrite),
        .cmd_addr(cmdAddr),
        .cmd_size(cmdSize),
        .cmd_wdata(cmdWdata),
        .rsp_valid(rspValid),
        .rsp_rdata(rspRdata),
        .rsp_error(rspError),
        .busy(busy),
        .HADDR(haddr),
        .HTRANS(htrans),
        .HWRITE(hwrite),
        .HSIZE(hsize),
        .HBURST(hburst),
        .HPROT(hprot),
        .HWDATA(hwdata),
        .HREADY(hready),
        .HRDATA(hrdata),
        .HRESP(hresp)
    );

    // Free-running 10-unit clock.
    always #5 hclk = ~hclk;

    // Transaction-level model.
    // addrQ holds accepted commands whose address phase has not finished.
    // dataQ holds commands whose data phase has not finished.
    // An AHB phase finishes on any rising edge where HREADY is high.
    typedef struct {
        logic        write;
        logic [31:0] addr;
        logic [1:0]  size;
        logic [31:0] wdata;
    } cmdT;

    cmdT         addrQ[$];
    cmdT         dataQ[$];
    cmdT         mCmd;
    logic        mAccept;
    logic        rspDue = 1'b0;
    logic [31:0] rspExpData = '0;
    logic        rspExpErr = 1'b0;

    function automatic logic [1:0] effSize(input logic [1:0] s);
        return (s == 2'd3) ? 2'd2 : s;
    endfunction

    function automatic logic [31:0] alignedAddr(input logic [31:0] a, input logic [1:0] s);
        logic [31:0] mask;
        mask = (32'd1 << effSize(s)) - 32'd1;
        return a & ~mask;
    endfunction

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%08h expected 0x%08h at %0t", name, actual, expected, $time);
        end
    endtask

    // Model update on each rising edge, driven only by bench-side inputs.
    always @(posedge hclk) begin
        if (hreset) begin
            addrQ.delete();
            dataQ.delete();
            rspDue     = 1'b0;
            rspExpData = '0;
            rspExpErr  = 1'b0;
        end else begin
            mAccept = cmdValid && (addrQ.size() == 0 || hready);
            rspDue  = 1'b0;
            if (hready && dataQ.size() != 0) begin
                mCmd       = dataQ.pop_front();
                rspDue     = 1'b1;
                rspExpData = mCmd.write ? 32'd0 : hrdata;
                rspExpErr  = hresp;
            end
            if (hready && addrQ.size() != 0) begin
                dataQ.push_back(addrQ.pop_front());
            end
            if (mAccept) begin
                mCmd.write = cmdWrite;
                mCmd.addr  = cmdAddr;
                mCmd.size  = cmdSize;
                mCmd.wdata = cmdWdata;
                addrQ.push_back(mCmd);
            end
        end
    end

    // Compare the DUT against the model on every falling edge.
    always @(negedge hclk) begin
        if (modelOn) begin
            checkOutput("cmd_ready", 32'(cmdReady), 32'(!hreset && (addrQ.size() == 0 || hready)));
            checkOutput("htrans", 32'(htrans), (addrQ.size() != 0) ? 32'd2 : 32'd0);
            if (addrQ.size() != 0) begin
                checkOutput("haddr", haddr, alignedAddr(addrQ[0].addr, addrQ[0].size));
                checkOutput("hwrite", 32'(hwrite), 32'(addrQ[0].write));
                checkOutput("hsize", 32'(hsize), 32'(effSize(addrQ[0].size)));
            end
            checkOutput("busy", 32'(busy), 32'((addrQ.size() + dataQ.size()) != 0));
            checkOutput("hwdata", hwdata, (dataQ.size() != 0 && dataQ[0].write) ? dataQ[0].wdata : 32'd0);
            checkOutput("rsp_valid", 32'(rspValid), 32'(rspDue));
            if (rspDue) begin
                checkOutput("rsp_rdata", rspRdata, rspExpData);
                checkOutput("rsp_error", 32'(rspError), 32'(rspExpErr));
            end
            checkOutput("hburst", 32'(hburst), 32'd0);
            checkOutput("hprot", 32'(hprot), 32'd3);
        end
    end

    task automatic applyStimulus(input logic v, input logic w, input logic [31:0] a,
                                 input logic [1:0] s, input logic [31:0] d);
        cmdValid = v;
        cmdWrite = w;
        cmdAddr  = a;
        cmdSize  = s;
        cmdWdata = d;
    endtask

    task automatic setSlave(input logic rdy, input logic resp, input logic [31:0] data);
        hready = rdy;
        hresp  = resp;
        hrdata = data;
    endtask

    task automatic nextCycle();
        @(posedge hclk);
        #1;
    endtask

    // Safety net so the run always ends.
    initial begin
        #100000;
        $display("[TB] FAIL watchdog: got timeout expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    // Directed scenarios.
    initial begin
        hreset = 1'b1;
        applyStimulus(1'b0, 1'b0, 32'd0, 2'd0, 32'd0);
        setSlave(1'b1, 1'b0, 32'd0);
        nextCycle();
        nextCycle();
        modelOn = 1'b1;

        // Reset state.
        checkOutput("rst_htrans", 32'(htrans), 32'd0);
        checkOutput("rst_haddr", haddr, 32'd0);
        checkOutput("rst_hwrite", 32'(hwrite), 32'd0);
        checkOutput("rst_hsize", 32'(hsize), 32'd0);
        checkOutput("rst_busy", 32'(busy), 32'd0);
        checkOutput("rst_ready", 32'(cmdReady), 32'd0);
        checkOutput("rst_rsp_valid", 32'(rspValid), 32'd0);
        hreset = 1'b0;
        nextCycle();

        // Write with no wait states.
        applyStimulus(1'b1, 1'b1, 32'h4000_0004, 2'd2, 32'hDEAD_BEEF);
        nextCycle();
        applyStimulus(1'b0, 1'b0, 32'd0, 2'd0, 32'd0);
        checkOutput("wr_htrans_t1", 32'(htrans), 32'd2);
        checkOutput("wr_haddr_t1", haddr, 32'h4000_0004);
        checkOutput("wr_hwrite_t1", 32'(hwrite), 32'd1);
        checkOutput("wr_hsize_t1", 32'(hsize), 32'd2);
        nextCycle();
        checkOutput("wr_hwdata_t2", hwdata, 32'hDEAD_BEEF);
        checkOutput("wr_rsp_early", 32'(rspValid), 32'd0);
        nextCycle();
        checkOutput("wr_rsp_t3", 32'(rspValid), 32'd1);
        checkOutput("wr_rsp_err", 32'(rspError), 32'd0);
        checkOutput("wr_rsp_data", rspRdata, 32'd0);
        nextCycle();
        checkOutput("wr_rsp_once", 32'(rspValid), 32'd0);

        // Read with three wait states.
        applyStimulus(1'b1, 1'b0, 32'h4000_0008, 2'd2, 32'd0);
        nextCycle();
        applyStimulus(1'b0, 1'b0, 32'd0, 2'd0, 32'd0);
        checkOutput("rd_htrans_t1", 32'(htrans), 32'd2);
        nextCycle();
        checkOutput("rd_htrans_t2", 32'(htrans), 32'd0);
        setSlave(1'b0, 1'b0, 32'd0);
        nextCycle();
        nextCycle();
        nextCycle();
        checkOutput("rd_rsp_t5", 32'(rspValid), 32'd0);
        setSlave(1'b1, 1'b0, 32'h1234_5678);
        nextCycle();
        setSlave(1'b1, 1'b0, 32'd0);
        checkOutput("rd_rsp_t6", 32'(rspValid), 32'd1);
        checkOutput("rd_rsp_data", rspRdata, 32'h1234_5678);
        nextCycle();
        checkOutput("rd_rsp_once", 32'(rspValid), 32'd0);

        // Back-to-back mixed writes and reads.
        pulses = 0;
        for (int i = 0; i < 4; i++) begin
            applyStimulus(1'b1, (i % 2) == 0, 32'h200 + 32'(4 * i), 2'd2, 32'hA5A5_0000 + 32'(i));
            setSlave(1'b1, 1'b0, 32'hC0DE_0000 + 32'(i));
            #1;
            checkOutput("b2b_ready", 32'(cmdReady), 32'd1);
            nextCycle();
            checkOutput("b2b_htrans", 32'(htrans), 32'd2);
            checkOutput("b2b_haddr", haddr, 32'h200 + 32'(4 * i));
            if (rspValid) pulses++;
        end
        applyStimulus(1'b0, 1'b0, 32'd0, 2'd0, 32'd0);
        for (int i = 0; i < 4; i++) begin
            setSlave(1'b1, 1'b0, 32'hC0DE_0010 + 32'(i));
            nextCycle();
            if (rspValid) pulses++;
        end
        setSlave(1'b1, 1'b0, 32'd0);
        checkOutput("b2b_pulses", 32'(pulses), 32'd4);

        // Alignment and backpressure.
        applyStimulus(1'b1, 1'b0, 32'h103, 2'd1, 32'd0);
        nextCycle();
        checkOutput("al_half_addr", haddr, 32'h102);
        checkOutput("al_half_size", 32'(hsize), 32'd1);
        applyStimulus(1'b1, 1'b1, 32'h103, 2'd2, 32'h55AA_55AA);
        nextCycle();
        checkOutput("al_word_addr", haddr, 32'h100);
        checkOutput("al_word_size", 32'(hsize), 32'd2);
        setSlave(1'b0, 1'b0, 32'd0);
        applyStimulus(1'b1, 1'b1, 32'h107, 2'd0, 32'h7700_0000);
        #1;
        checkOutput("bp_ready_low", 32'(cmdReady), 32'd0);
        nextCycle();
        checkOutput("bp_hold_addr", haddr, 32'h100);
        nextCycle();
        setSlave(1'b1, 1'b0, 32'd0);
        #1;
        checkOutput("bp_ready_high", 32'(cmdReady), 32'd1);
        nextCycle();
        applyStimulus(1'b0, 1'b0, 32'd0, 2'd0, 32'd0);
        checkOutput("bp_byte_addr", haddr, 32'h107);
        checkOutput("bp_byte_size", 32'(hsize), 32'd0);
        nextCycle();
        nextCycle();
        nextCycle();

        // Error response on the first of two pipelined reads.
        applyStimulus(1'b1, 1'b0, 32'h300, 2'd2, 32'd0);
        nextCycle();
        applyStimulus(1'b1, 1'b0, 32'h304, 2'd2, 32'd0);
        nextCycle();
        applyStimulus(1'b0, 1'b0, 32'd0, 2'd0, 32'd0);
        setSlave(1'b0, 1'b1, 32'd0);
        nextCycle();
        setSlave(1'b1, 1'b1, 32'd0);
        nextCycle();
        setSlave(1'b1, 1'b0, 32'hBEEF_0001);
        checkOutput("err_rsp1_valid", 32'(rspValid), 32'd1);
        checkOutput("err_rsp1_err", 32'(rspError), 32'd1);
        nextCycle();
        setSlave(1'b1, 1'b0, 32'd0);
        checkOutput("err_rsp2_valid", 32'(rspValid), 32'd1);
        checkOutput("err_rsp2_err", 32'(rspError), 32'd0);
        checkOutput("err_rsp2_data", rspRdata, 32'hBEEF_0001);
        nextCycle();

        // Reset during a data-phase wait state.
        applyStimulus(1'b1, 1'b0, 32'h400, 2'd2, 32'd0);
        nextCycle();
        applyStimulus(1'b0, 1'b0, 32'd0, 2'd0, 32'd0);
        nextCycle();
        setSlave(1'b0, 1'b0, 32'd0);
        nextCycle();
        hreset = 1'b1;
        nextCycle();
        checkOutput("mr_htrans", 32'(htrans), 32'd0);
        checkOutput("mr_busy", 32'(busy), 32'd0);
        checkOutput("mr_rsp", 32'(rspValid), 32'd0);
        hreset = 1'b0;
        setSlave(1'b1, 1'b0, 32'd0);
        nextCycle();
        checkOutput("mr_rsp_after", 32'(rspValid), 32'd0);
        applyStimulus(1'b1, 1'b1, 32'h404, 2'd2, 32'h0BAD_F00D);
        nextCycle();
        applyStimulus(1'b0, 1'b0, 32'd0, 2'd0, 32'd0);
        nextCycle();
        checkOutput("mr_hwdata", hwdata, 32'h0BAD_F00D);
        nextCycle();
        checkOutput("mr_new_rsp", 32'(rspValid), 32'd1);
        checkOutput("mr_new_err", 32'(rspError), 32'd0);
        nextCycle();
        nextCycle();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/ahb_lite_master.md
Name: ahb_lite_master

Overview:
- Single-initiator AHB-lite bus master. Converts a simple valid/ready command stream into AHB-lite SINGLE transfers and returns one response per command, in order.
- Drives the HSEL-decoded slave fabric that peripherals such as the SPI slave sit on, so accelerator and test logic can issue bus reads and writes without hand-sequencing HTRANS.
- Pipelined: the address phase of command N+1 overlaps the data phase of command N.

Parameters:
- ADDR_W, 32, address width of cmd_addr and HADDR.
- DATA_W, 32, data width. Only 32 is supported.
- HPROT_VAL, 4'b0011, constant driven on HPROT (non-cacheable, privileged data access).

Ports:
- HCLK  in  1  clock; all logic is on the rising edge.
- HRESET  in  1  synchronous, active-high reset.
- cmd_valid  in  1  command present.
- cmd_ready  out  1  command accepted when cmd_valid && cmd_ready.
- cmd_write  in  1  1 = write, 0 = read.
- cmd_addr  in  ADDR_W  byte address.
- cmd_size  in  2  0 = byte, 1 = halfword, 2 = word; 3 is treated as 2.
- cmd_wdata  in  DATA_W  write data, already placed in the correct byte lanes.
- rsp_valid  out  1  single-cycle pulse when one transfer completes.
- rsp_rdata  out  DATA_W  raw HRDATA for reads; 0 for writes.
- rsp_error  out  1  HRESP was ERROR for this transfer.
- busy  out  1  address-stage or data-stage valid.
- HADDR  out  ADDR_W  AHB address.
- HTRANS  out  2  IDLE = 2'b00 or NONSEQ = 2'b10 only.
- HWRITE  out  1  AHB direction.
- HSIZE  out  3  {1'b0, size}.
- HBURST  out  3  constant 3'b000 (SINGLE).
- HPROT  out  4  constant HPROT_VAL.
- HWDATA  out  DATA_W  data-phase write data.
- HREADY  in  1  global bus ready.
- HRDATA  in  DATA_W  read data.
- HRESP  in  1  0 = OKAY, 1 = ERROR.

Behaviour:
- Internal structure: two registered stages.
  - Address stage (a_vld): drives HADDR, HTRANS, HWRITE, HSIZE.
  - Data stage (d_vld, d_write, d_wdata).
- cmd_ready = !HRESET && (!a_vld || HREADY). This is combinational; there is no path from cmd_valid to cmd_ready.
- On accept, at the clock edge:
  - a_vld <= 1.
  - HTRANS <= NONSEQ; HWRITE, HSIZE, HADDR loaded from the command.
  - HADDR[0] is forced to 0 when size = 1; HADDR[1:0] are forced to 0 when size >= 2.
- Address stage with no new command: if a_vld && HREADY, then a_vld <= 0 and HTRANS <= IDLE.
  - HADDR, HWRITE and HSIZE hold their last values while HTRANS is IDLE.
- Address stage to data stage: when a_vld && HREADY, then d_vld <= 1 and d_write, d_wdata are captured.
  - Otherwise, when d_vld && HREADY, d_vld <= 0.
  - Both moves can happen on the same edge.
- HWDATA = d_wdata while d_vld && d_write; otherwise 0. It is held constant through wait states (HREADY = 0).
- Completion: when d_vld && HREADY, on the next cycle:
  - rsp_valid = 1 for exactly one cycle.
  - rsp_rdata = HRDATA if read, else 0.
  - rsp_error = HRESP.
  - rsp_valid has no backpressure; the consumer must always accept it.
- Latency with zero wait states:
  - Accept edge at cycle T.
  - NONSEQ on the bus in T+1; data phase in T+2.
  - rsp_valid in T+3.
  - Each wait state adds 1 cycle.
- Throughput: one transfer per cycle with zero wait states.
- Error response (HRESP = 1 for two cycles, HREADY low then high):
  - A pending address phase is not cancelled; it continues (legal in AHB-lite).
  - The error is reported only on the completing cycle.
  - The next command's response follows normally.
- HREADY held low: all outputs stay frozen and cmd_ready = !a_vld.
- busy = a_vld || d_vld.
- Reset, synchronous and active-high, takes priority over everything:
  - a_vld = d_vld = 0, HTRANS = IDLE, HADDR = 0, HWRITE = 0, HSIZE = 0, HWDATA = 0.
  - rsp_valid = 0, rsp_rdata = 0, rsp_error = 0.
  - cmd_ready = 0 while HRESET is high; busy = 0.
  - Reset mid-transfer abandons in-flight commands; no response is produced for them.

Test Plan:
- Write, no wait states: cmd write addr 0x40000004, data 0xDEADBEEF, size 2 at T -> NONSEQ/HWRITE = 1/HADDR = 0x40000004 in T+1; HWDATA = 0xDEADBEEF in T+2; rsp_valid in T+3 with rsp_error = 0 and rsp_rdata = 0.
- Read, 3 wait states: read 0x40000008; slave holds HREADY low 3 cycles, then returns 0x12345678 -> HTRANS returns to IDLE after the address phase; rsp_valid at T+6 with rsp_rdata = 0x12345678; exactly one pulse.
- Back-to-back: 4 commands on consecutive cycles with cmd_valid held and HREADY = 1 -> NONSEQ for 4 consecutive cycles; 4 rsp_valid pulses on consecutive cycles, in order; cmd_ready stays 1.
- Alignment and backpressure: halfword at 0x103, then word at 0x103 -> HADDR = 0x102 (HSIZE = 1), then HADDR = 0x100 (HSIZE = 2); during a wait state with a_vld set, cmd_ready = 0 and the command is held unaccepted.
- Error: slave returns HRESP = 1, HREADY = 0, then HRESP = 1, HREADY = 1 on the first of two pipelined reads -> first response has rsp_error = 1; second read still issued and completes with rsp_error = 0.
- Reset mid-operation: assert HRESET one cycle during a data-phase wait state -> next cycle HTRANS = IDLE, busy = 0, rsp_valid stays 0; a new command after reset completes normally.
